cache_line_axi_bridge: RTL and testbench
========================================

# cache_line_axi_bridge

Slave-side responder for the cache's line-refill/writeback bus (rd_req/ret_valid/wr_req/wr_valid). It converts one whole-line read or write request from the I/D caches into a single AXI4 INCR burst, then returns the assembled line or the write completion to the cache. The read and write paths are independent state machines, so one refill and one writeback can be in flight together. It sits between the cache and the AXI crossbar; uncached traffic does not pass through it.

## Interface
- LINE_WORD, 4, 32-bit words per cache line (power of two, 2..16); burst length = LINE_WORD beats
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  line refill request
- rd_addr  in  32  refill address (any byte within the line)
- rd_rdy  out  1  read path idle; request accepted when rd_req && rd_rdy
- ret_valid  out  1  one-cycle pulse, ret_data valid
- ret_data  out  LINE_WORD*32  refilled line, word 0 in bits [31:0]
- wr_req  in  1  writeback request
- wr_addr  in  32  writeback address
- wr_data  in  LINE_WORD*32  line to write, word 0 in bits [31:0]
- wr_rdy  out  1  write path idle; accepted when wr_req && wr_rdy
- wr_valid  out  1  one-cycle pulse, write acknowledged by B channel
- araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1;  arready  in  1
- rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1
- awaddr/awlen/awsize/awburst/awvalid  out  32/8/3/2/1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wlast  out  1;  wvalid  out  1;  wready  in  1
- bresp  in  2;  bvalid  in  1;  bready  out  1

## Operation
- Burst fields constant: arlen/awlen = LINE_WORD-1, arsize/awsize = 3'b010, arburst/awburst = 2'b01, wstrb = 4'hF.
- Addresses line-aligned: low log2(LINE_WORD*4) bits forced to 0, captured at acceptance.
- Read FSM: R_IDLE -> (accept) R_AR -> (arvalid&&arready) R_DATA -> (rvalid&&rready&&rlast) R_DONE -> R_IDLE. rd_rdy = (state==R_IDLE). arvalid high only in R_AR, held until arready. rready high only in R_DATA. Beat counter (log2(LINE_WORD) bits, reset to 0 on accept) places rdata into word[cnt]. ret_valid high only in R_DONE; ret_data holds its value until next accept. rresp ignored.
- Write FSM: W_IDLE -> (accept, wr_data latched) W_AW -> (awready) W_DATA -> (wready on last beat) W_B -> (bvalid) W_DONE -> W_IDLE. wr_rdy = (state==W_IDLE). W beats start only after AW handshake; wdata = word[cnt], wlast when cnt==LINE_WORD-1; wvalid continuous in W_DATA. bready high only in W_B. wr_valid high only in W_DONE. bresp ignored.
- Read and write paths advance concurrently; no ordering between them except the configured hazard hold.

## Timing
- Reset (rst high at a rising edge): both FSMs to idle, counters 0, ret_data 0. Outputs after reset: rd_rdy=1, wr_rdy=1, all AXI valid/ready outputs 0, ret_valid=0, wr_valid=0. Reset mid-burst abandons the transaction; no ret_valid/wr_valid is emitted.
- Read accepted in cycle T: arvalid at T+1; with arready at T+1 and rvalid every cycle, beats T+2..T+1+LINE_WORD, ret_valid at T+2+LINE_WORD, rd_rdy again at T+3+LINE_WORD. Minimum read occupancy LINE_WORD+3 cycles.
- Write accepted at T: awvalid T+1; first wvalid T+2 (if awready at T+1); wr_valid one cycle after bvalid&&bready.
- Stalls (arready/rvalid/wready/awready/bvalid low) hold state and counter; no beat is skipped or duplicated.
- rlast early: read completes, unwritten words keep previous contents. Beat after count LINE_WORD-1 without rlast: counter wraps to 0.

## Configuration
- CACHE_BRIDGE_RAW_HOLD_EN defined: extra read state R_HOLD. An accepted read whose aligned line equals the aligned line of a write in any non-idle write state, or of a write accepted in the same cycle, enters R_HOLD instead of R_AR and leaves to R_AR the cycle after the write FSM returns to W_IDLE. Guarantees refill returns the just-written data.
- Not defined: no R_HOLD; reads issue immediately regardless of pending writes.

## Test plan
- Read rd_addr=0x1FC0_0014, LINE_WORD=4, slave returns 0x11,0x22,0x33,0x44 no stalls -> araddr=0x1FC0_0010, arlen=3, ret_valid at T+6, ret_data=0x44_33_22_11 word order (word0=0x11).
- Write wr_addr=0x0000_1238, wr_data words A0..A3, wready toggled every other cycle -> awaddr=0x0000_1230, wdata sequence A0,A1,A2,A3 with wlast only on A3, wr_valid one cycle after bvalid.
- Concurrent read 0x100 and write 0x200 same cycle, RAW hold enabled -> both arvalid and awvalid at T+1, both complete independently.
- RAW enabled: write 0x300 accepted, bvalid delayed 10 cycles, read 0x304 accepted -> arvalid stays 0 until cycle after W_IDLE; disabled -> arvalid at T+1.
- rst asserted during R_DATA beat 2 -> next cycle rd_rdy=1, rready=0, no ret_valid; new read then completes normally with counter from 0.

Source files
------------

// File: rtl/cache_line_axi_bridge.sv
// cache_line_axi_bridge: turns whole-line cache refills and writebacks into
// single AXI4 INCR bursts; read and write paths run as independent FSMs.
// Optional build macro CACHE_BRIDGE_RAW_HOLD_EN: holds a refill (R_HOLD) while a
// writeback to the same line is still in flight, so the refill sees the new data.
module cache_line_axi_bridge #(
  parameter int unsigned LINE_WORD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  // cache refill side
  input  logic                     rd_req,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic [LINE_WORD*32-1:0]  ret_data,
  // cache writeback side
  input  logic                     wr_req,
  input  logic [31:0]              wr_addr,
  input  logic [LINE_WORD*32-1:0]  wr_data,
  output logic                     wr_rdy,
  output logic                     wr_valid,
  // AXI read address / data
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI write address / data / response
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int unsigned CNT_W = $clog2(LINE_WORD);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORD * 4) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORD - 1);

  typedef enum logic [2:0] {R_IDLE, R_AR, R_DATA, R_DONE, R_HOLD} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_B, W_DONE} wr_state_e;

  rd_state_e        rd_state_q, rd_state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [31:0]      ret_word_q [LINE_WORD];
  logic             rd_rdy_q, arvalid_q, rready_q, ret_valid_q;
  logic [31:0]      araddr_q;

  wr_state_e        wr_state_q, wr_state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [31:0]      wbuf_q [LINE_WORD];
  logic             wr_rdy_q, awvalid_q, wvalid_q, wlast_q, bready_q, wr_valid_q;
  logic [31:0]      awaddr_q, wdata_q;

  logic [31:0]      rd_line_c, wr_line_c;
  logic             rd_hazard_c;
  logic             unused_resp;

  assign rd_line_c   = rd_addr & LINE_MASK;
  assign wr_line_c   = wr_addr & LINE_MASK;
  assign unused_resp = ^{rresp, bresp};

`ifdef CACHE_BRIDGE_RAW_HOLD_EN
  // Same-line write pending or accepted this cycle: refill must wait for it.
  assign rd_hazard_c = ((wr_state_q != W_IDLE) && (rd_line_c == awaddr_q)) ||
                       (wr_req && (wr_state_q == W_IDLE) && (rd_line_c == wr_line_c));
`else
  assign rd_hazard_c = 1'b0;
`endif

  // Fixed burst shape: full line, 32-bit beats, incrementing.
  assign arlen   = 8'(LINE_WORD - 1);
  assign awlen   = 8'(LINE_WORD - 1);
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wstrb   = 4'hF;

  assign rd_rdy    = rd_rdy_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;
  assign ret_valid = ret_valid_q;
  assign wr_rdy    = wr_rdy_q;
  assign wr_valid  = wr_valid_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wlast     = wlast_q;
  assign bready    = bready_q;

  // Pack the refill word registers into the line bus, word 0 lowest.
  always_comb begin
    ret_data = '0;
    for (int i = 0; i < int'(LINE_WORD); i++) begin
      ret_data[i*32 +: 32] = ret_word_q[i];
    end
  end

  // Read path next state and beat counter.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req) begin
          rd_cnt_d   = '0;
          rd_state_d = rd_hazard_c ? R_HOLD : R_AR;
        end
      end
      R_HOLD:  if (wr_state_q == W_IDLE) rd_state_d = R_AR;
      R_AR:    if (arready) rd_state_d = R_DATA;
      R_DATA: begin
        if (rvalid && rready_q) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rlast) rd_state_d = R_DONE;
        end
      end
      R_DONE:  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read path state, registered handshake outputs and line assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      rd_cnt_q    <= '0;
      rd_rdy_q    <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      araddr_q    <= '0;
      for (int i = 0; i < int'(LINE_WORD); i++) ret_word_q[i] <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_rdy_q    <= (rd_state_d == R_IDLE);
      arvalid_q   <= (rd_state_d == R_AR);
      rready_q    <= (rd_state_d == R_DATA);
      ret_valid_q <= (rd_state_d == R_DONE);
      if ((rd_state_q == R_IDLE) && rd_req) araddr_q <= rd_line_c;
      if ((rd_state_q == R_DATA) && rvalid && rready_q) ret_word_q[rd_cnt_q] <= rdata;
    end
  end

  // Write path next state and beat counter.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wr_cnt_d   = '0;
          wr_state_d = W_AW;
        end
      end
      W_AW:    if (awready) wr_state_d = W_DATA;
      W_DATA: begin
        if (wready && wvalid_q) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LAST_BEAT) wr_state_d = W_B;
        end
      end
      W_B:     if (bvalid) wr_state_d = W_DONE;
      W_DONE:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write path state, line buffer and registered W-channel beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      wr_rdy_q   <= 1'b1;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < int'(LINE_WORD); i++) wbuf_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_rdy_q   <= (wr_state_d == W_IDLE);
      awvalid_q  <= (wr_state_d == W_AW);
      wvalid_q   <= (wr_state_d == W_DATA);
      bready_q   <= (wr_state_d == W_B);
      wr_valid_q <= (wr_state_d == W_DONE);
      wdata_q    <= wbuf_q[wr_cnt_d];
      wlast_q    <= (wr_state_d == W_DATA) && (wr_cnt_d == LAST_BEAT);
      if ((wr_state_q == W_IDLE) && wr_req) begin
        awaddr_q <= wr_line_c;
        for (int i = 0; i < int'(LINE_WORD); i++) wbuf_q[i] <= wr_data[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_cache_line_axi_bridge.sv
// Directed bench for cache_line_axi_bridge: an AXI slave model plus a per-cycle
// checker derived from the line/burst rules, and hand-computed expectations.
module tb_cache_line_axi_bridge;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0]     rd_addr = '0, wr_addr = '0;
  logic [LW*32-1:0] wr_data = '0;
  logic            rd_rdy, ret_valid, wr_rdy, wr_valid;
  logic [LW*32-1:0] ret_data;
  logic [31:0]     araddr, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic            arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]      wstrb;
  logic            arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic            rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0;
  logic [31:0]     rdata = '0;
  logic [1:0]      rresp = 2'b00, bresp = 2'b00;

  cache_line_axi_bridge #(.LINE_WORD(LW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: slave knobs and the expected view of the bridge.
  logic [31:0] rd_words [16];
  logic [31:0] exp_line [LW];
  logic [31:0] exp_w [LW];
  logic [31:0] exp_araddr = '0, exp_awaddr = '0;
  int  rlast_at = LW - 1;
  bit  r_stall = 0, w_toggle = 0, tog = 0;
  bit  rd_pend = 0, aw_done = 0, b_pend = 0;
  int  rbeat = 0, wbeat = 0, b_wait = 0, b_delay = 0;
  bit  ar_arm = 0, aw_arm = 0, w_arm = 0;
  int  ar_first = -1, aw_first = -1, w_first = -1;
  int  r_end = -1, ret_cyc = -1, b_hs = -1, wv_cyc = -1;
  int  ret_cnt = 0, wr_cnt = 0;

  function automatic logic [LW*32-1:0] pack_line();
    logic [LW*32-1:0] v;
    for (int i = 0; i < LW; i++) v[i*32 +: 32] = exp_line[i];
    return v;
  endfunction

  // Slave model and per-cycle compare, evaluated mid-cycle on the falling edge.
  initial begin : model
    for (int i = 0; i < LW; i++) exp_line[i] = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (rst) begin
        rd_pend = 0; aw_done = 0; b_pend = 0; wbeat = 0; rbeat = 0;
        rvalid = 0; rlast = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
        for (int i = 0; i < LW; i++) exp_line[i] = '0;
      end else begin
        if (arvalid) begin
          check("arlen", arlen, 8'd3);
          check("arsize", arsize, 3'b010);
          check("arburst", arburst, 2'b01);
          check("araddr", araddr, exp_araddr);
          if (ar_arm) begin ar_first = cyc; ar_arm = 0; end
        end
        if (awvalid) begin
          check("awlen", awlen, 8'd3);
          check("awsize", awsize, 3'b010);
          check("awburst", awburst, 2'b01);
          check("awaddr", awaddr, exp_awaddr);
          if (aw_arm) begin aw_first = cyc; aw_arm = 0; end
        end
        if (rready) check("rready_phase", rd_pend, 1'b1);
        if (bready) check("bready_phase", b_pend, 1'b1);
        // B channel
        bvalid = b_pend && (b_wait == 0);
        if (bvalid && bready) begin b_hs = cyc; b_pend = 0; end
        else if (b_pend && b_wait > 0) b_wait--;
        // W channel
        wready = w_toggle ? tog : 1'b1;
        if (wvalid) begin
          check("wstrb", wstrb, 4'hF);
          if (w_arm) begin w_first = cyc; w_arm = 0; end
        end
        if (wvalid && wready) begin
          check("w_after_aw", aw_done, 1'b1);
          check("wdata", wdata, exp_w[wbeat]);
          check("wlast", wlast, wbeat == LW - 1);
          if (wbeat == LW - 1) begin
            wbeat = 0; aw_done = 0; b_pend = 1; b_wait = b_delay;
          end else wbeat++;
        end
        // AW channel
        awready = 1'b1;
        if (awvalid && awready) aw_done = 1;
        // R channel
        if (rd_pend) begin
          rvalid = r_stall ? tog : 1'b1;
          rdata  = rd_words[rbeat];
          rlast  = (rbeat == rlast_at);
        end else begin
          rvalid = 0; rlast = 0; rdata = '0;
        end
        if (rvalid && rready) begin
          exp_line[rbeat % LW] = rdata;
          if (rlast) begin rd_pend = 0; r_end = cyc; end
          rbeat++;
        end
        // AR channel
        arready = 1'b1;
        if (arvalid && arready) begin rd_pend = 1; rbeat = 0; end
        // completions back to the cache
        if (ret_valid) begin
          ret_cnt++; ret_cyc = cyc;
          check("ret_data", ret_data, pack_line());
          check("ret_lat", cyc, r_end + 1);
        end
        if (wr_valid) begin
          wr_cnt++; wv_cyc = cyc;
          check("wr_valid_lat", cyc, b_hs + 1);
        end
      end
    end
  end

  task automatic set_read(input logic [31:0] a, input logic [31:0] ea);
    for (int i = 0; i < 300 && !rd_rdy; i++) begin @(posedge clk); #1; end
    check("rd_rdy_wait", rd_rdy, 1'b1);
    rd_req = 1; rd_addr = a; exp_araddr = ea; ar_arm = 1;
  endtask

  task automatic set_write(input logic [31:0] a, input logic [31:0] ea);
    for (int i = 0; i < 300 && !wr_rdy; i++) begin @(posedge clk); #1; end
    check("wr_rdy_wait", wr_rdy, 1'b1);
    wr_req = 1; wr_addr = a; exp_awaddr = ea; aw_arm = 1; w_arm = 1;
    for (int i = 0; i < LW; i++) wr_data[i*32 +: 32] = exp_w[i];
  endtask

  task automatic go();
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
  endtask

  task automatic wait_ret(input int target);
    for (int i = 0; i < 300 && ret_cnt < target; i++) begin @(posedge clk); #1; end
    check("ret_timeout", ret_cnt >= target, 1'b1);
  endtask

  task automatic wait_wr(input int target);
    for (int i = 0; i < 300 && wr_cnt < target; i++) begin @(posedge clk); #1; end
    check("wr_timeout", wr_cnt >= target, 1'b1);
  endtask

  int t0, t1, saved;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_rd_rdy", rd_rdy, 1'b1);
    check("rst_wr_rdy", wr_rdy, 1'b1);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_ret_valid", ret_valid, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_ret_data", ret_data, '0);
    @(posedge clk); #1;

    // Refill of 0x1FC0_0014, no stalls.
    rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
    set_read(32'h1FC0_0014, 32'h1FC0_0010);
    t0 = cyc; go();
    wait_ret(1);
    check("t1_ar_lat", ar_first, t0 + 1);
    check("t1_ret_lat", ret_cyc, t0 + 6);
    check("t1_ret_data", ret_data, 128'h00000044_00000033_00000022_00000011);
    check("t1_rd_rdy", rd_rdy, 1'b1);

    // Writeback of 0x1238 with wready toggling.
    exp_w[0] = 32'hA000_00A0; exp_w[1] = 32'hA111_00A1;
    exp_w[2] = 32'hA222_00A2; exp_w[3] = 32'hA333_00A3;
    w_toggle = 1; b_delay = 2;
    set_write(32'h0000_1238, 32'h0000_1230);
    t0 = cyc; go();
    wait_wr(1);
    check("t2_aw_lat", aw_first, t0 + 1);
    check("t2_w_first", w_first, t0 + 2);
    check("t2_wr_rdy", wr_rdy, 1'b1);

    // Concurrent refill 0x100 and writeback 0x200.
    w_toggle = 0; b_delay = 0;
    for (int i = 0; i < LW; i++) rd_words[i] = 32'h101 + 32'(i);
    exp_w[0] = 32'hB0; exp_w[1] = 32'hB1; exp_w[2] = 32'hB2; exp_w[3] = 32'hB3;
    set_read(32'h0000_0100, 32'h0000_0100);
    set_write(32'h0000_0200, 32'h0000_0200);
    t0 = cyc; go();
    wait_ret(2);
    wait_wr(2);
    check("t3_ar_lat", ar_first, t0 + 1);
    check("t3_aw_lat", aw_first, t0 + 1);
    check("t3_ret_data", ret_data, 128'h00000104_00000103_00000102_00000101);

    // Refill to a line with a writeback still awaiting its response.
    b_delay = 10;
    exp_w[0] = 32'hC0; exp_w[1] = 32'hC1; exp_w[2] = 32'hC2; exp_w[3] = 32'hC3;
    set_write(32'h0000_0300, 32'h0000_0300);
    go();
    set_read(32'h0000_0304, 32'h0000_0300);
    t1 = cyc; go();
    wait_wr(3);
    wait_ret(3);
`ifdef CACHE_BRIDGE_RAW_HOLD_EN
    check("t4_ar_held", ar_first, wv_cyc + 2);
`else
    check("t4_ar_lat", ar_first, t1 + 1);
`endif
    b_delay = 0;

    // Reset while the third refill beat is on the bus.
    rd_words[0] = 32'hB0; rd_words[1] = 32'hB1; rd_words[2] = 32'hB2; rd_words[3] = 32'hB3;
    set_read(32'h0000_2000, 32'h0000_2000);
    t0 = cyc; go();
    for (int i = 0; i < 50 && cyc < t0 + 4; i++) begin @(posedge clk); #1; end
    check("t5_reach_beat2", cyc, t0 + 4);
    saved = ret_cnt;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("t5_rd_rdy", rd_rdy, 1'b1);
    check("t5_rready", rready, 1'b0);
    check("t5_ret_valid", ret_valid, 1'b0);
    check("t5_ret_data", ret_data, '0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_ret", ret_cnt, saved);
    rd_words[0] = 32'hC0; rd_words[1] = 32'hC1; rd_words[2] = 32'hC2; rd_words[3] = 32'hC3;
    set_read(32'h0000_2044, 32'h0000_2040);
    go();
    wait_ret(saved + 1);
    check("t5_after_rst", ret_data, 128'h000000C3_000000C2_000000C1_000000C0);

    // Early rlast after two beats with rvalid stalls: upper words keep old data.
    rd_words[0] = 32'h55; rd_words[1] = 32'h66;
    rlast_at = 1; r_stall = 1;
    set_read(32'h0000_2080, 32'h0000_2080);
    go();
    wait_ret(saved + 2);
    check("t6_early_last", ret_data, 128'h000000C3_000000C2_00000066_00000055);

    // Six beats before rlast: counter wraps and overwrites words 0 and 1.
    for (int i = 0; i < 6; i++) rd_words[i] = 32'hD0 + 32'(i);
    rlast_at = 5; r_stall = 0;
    set_read(32'h0000_20C0, 32'h0000_20C0);
    go();
    wait_ret(saved + 3);
    check("t7_wrap", ret_data, 128'h000000D3_000000D2_000000D5_000000D4);
    rlast_at = LW - 1;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
